// File: rtl/dii_package.sv
// dii_package
// Shared types for the DII debug-ring stages.
//   DII_DATA_WIDTH : payload width of one flit (the destination word of a
//                    packet is carried in data[15:0] of its first flit)
//   flit_t         : one flit as stored in a buffer {data, first, last}
//   route_e        : where the current head flit is being sent
//   satInc         : 16-bit saturating increment used by packet counters
package dii_package;

  localparam int DII_DATA_WIDTH = 16;

  typedef struct packed {
    logic [DII_DATA_WIDTH-1:0] data;
    logic                      first;
    logic                      last;
  } flit_t;

  typedef enum logic [1:0] {
    ROUTE_LOCAL,
    ROUTE_RING,
    ROUTE_DROP
  } route_e;

  // Counters stick at all-ones rather than wrapping so that an overflowed
  // counter can never be mistaken for a small count.
  function automatic logic [15:0] satInc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/dii_channel.sv
// dii_channel
// One DII link: a flit (data/first/last) qualified by valid, with ready
// flowing back from the sink.
//   master : drives data, first, last, valid; receives ready
//   slave  : receives data, first, last, valid; drives ready
interface dii_channel #(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] data;
  logic                  first;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport master (output data, output first, output last, output valid, input ready);
  modport slave  (input data, input first, input last, input valid, output ready);

endinterface

// File: rtl/dii_skid_buffer.sv
// dii_skid_buffer
// Two-entry valid/ready buffer for DII flits. The upstream ready is a
// register, so no combinational path runs from downstream ready back to
// upstream ready; two entries are what it takes to keep one flit per cycle
// flowing while ready is registered.
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset (buffer empty, o_ready low)
//   i_flit   incoming flit
//   i_valid  incoming flit valid
//   o_ready  registered "buffer not full"; low during reset
//   o_flit   head flit (only meaningful while o_valid is high)
//   o_valid  buffer holds at least one flit
//   i_ready  downstream accepts the head flit this cycle
module dii_skid_buffer
  import dii_package::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  flit_t i_flit,
  input  logic  i_valid,
  output logic  o_ready,
  output flit_t o_flit,
  output logic  o_valid,
  input  logic  i_ready
);

  // The pointer and occupancy arithmetic below only works for two entries.
  generate
    if (BUF_DEPTH != 2) begin : g_badDepth
      $error("dii_skid_buffer: BUF_DEPTH must be 2");
    end
  endgenerate

  flit_t      r_mem [2];
  logic       r_wrPtr;
  logic       r_rdPtr;
  logic [1:0] r_count;
  logic       r_ready;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_countNext;

  assign w_push  = i_valid & r_ready;
  assign w_pop   = i_ready & o_valid;
  assign o_valid = (r_count != 2'd0);
  assign o_flit  = r_mem[r_rdPtr];
  assign o_ready = r_ready;

  // Occupancy after this cycle's push/pop; a push and a pop together leave
  // it unchanged, which is what sustains full throughput at occupancy 1.
  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + 2'd1;
      2'b01:   w_countNext = r_count - 2'd1;
      default: w_countNext = r_count;
    endcase
  end

  // Storage, pointers and the registered ready. Ready is computed from the
  // next occupancy so it drops in the same edge that fills the buffer, and
  // it rises on the first edge after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= i_flit;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= w_countNext;
      r_ready <= (w_countNext != 2'd2);
    end
  end

endmodule

// File: rtl/ring_router_demux.sv
// ring_router_demux
// Ingress stage of a debug ring router. Flits from the incoming ring link
// pass through a two-entry skid buffer; each packet is then steered by the
// destination word in its first flit: packets whose destination equals id
// go to out_local, everything else goes to out_ring (toward the round-robin
// merger). Flits that arrive without a preceding first flit are discarded.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   id         this router's DI address, compared only on first flits
//   in         incoming ring link (slave)
//   out_local  packets addressed to id (master)
//   out_ring   packets forwarded to the next ring hop (master)
// Optional build macro RING_ROUTER_DEMUX_STATS_EN adds saturating 16-bit
// completed-packet counters stat_local, stat_ring and stat_drop.
module ring_router_demux
  import dii_package::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [15:0] id,
  dii_channel.slave  in,
  dii_channel.master out_local,
  dii_channel.master out_ring
`ifdef RING_ROUTER_DEMUX_STATS_EN
  ,
  output logic [15:0] stat_local,
  output logic [15:0] stat_ring,
  output logic [15:0] stat_drop
`endif
);

  // Flits are stored in the shared flit_t, so the link width must match it.
  generate
    if (DATA_WIDTH != DII_DATA_WIDTH) begin : g_badWidth
      $error("ring_router_demux: DATA_WIDTH must equal DII_DATA_WIDTH");
    end
  endgenerate

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WORM_LOCAL = 2'd1;
  localparam logic [1:0] S_WORM_RING  = 2'd2;
  localparam logic [1:0] S_DROP       = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_stateNext;
  flit_t      w_inFlit;
  flit_t      w_head;
  logic       w_headValid;
  logic       w_inReady;
  logic       w_pop;
  logic       w_localValid;
  logic       w_ringValid;
  route_e     w_route;

  assign w_inFlit = '{data: in.data, first: in.first, last: in.last};
  assign in.ready = w_inReady;

  dii_skid_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_flit  (w_inFlit),
    .i_valid (in.valid),
    .o_ready (w_inReady),
    .o_flit  (w_head),
    .o_valid (w_headValid),
    .i_ready (w_pop)
  );

  // Route for the current head. Only in IDLE is the destination looked at;
  // inside a worm the locked route holds even if a flit carries first=1.
  always_comb begin
    w_route = ROUTE_DROP;
    case (r_state)
      S_IDLE: begin
        if (!w_head.first) begin
          w_route = ROUTE_DROP;
        end else if (w_head.data[15:0] == id) begin
          w_route = ROUTE_LOCAL;
        end else begin
          w_route = ROUTE_RING;
        end
      end
      S_WORM_LOCAL: w_route = ROUTE_LOCAL;
      S_WORM_RING:  w_route = ROUTE_RING;
      default:      w_route = ROUTE_DROP;
    endcase
  end

  assign w_localValid = w_headValid && (w_route == ROUTE_LOCAL);
  assign w_ringValid  = w_headValid && (w_route == ROUTE_RING);

  // The head leaves the buffer on a handshake with its selected output, or
  // unconditionally when it is being dropped.
  always_comb begin
    w_pop = 1'b0;
    case (w_route)
      ROUTE_LOCAL: w_pop = w_localValid & out_local.ready;
      ROUTE_RING:  w_pop = w_ringValid & out_ring.ready;
      default:     w_pop = w_headValid;
    endcase
  end

  // A popped last flit always ends the packet; otherwise the route taken by
  // the popped flit becomes (or stays) the locked state.
  always_comb begin
    w_stateNext = r_state;
    if (w_pop) begin
      if (w_head.last) begin
        w_stateNext = S_IDLE;
      end else begin
        case (w_route)
          ROUTE_LOCAL: w_stateNext = S_WORM_LOCAL;
          ROUTE_RING:  w_stateNext = S_WORM_RING;
          default:     w_stateNext = S_DROP;
        endcase
      end
    end
  end

  // Packet state register; reset abandons any worm in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Payload is zeroed on an output that is not valid, so the idle link
  // shows all-zero fields and only one output ever carries the head.
  assign out_local.valid = w_localValid;
  assign out_local.data  = w_localValid ? w_head.data  : '0;
  assign out_local.first = w_localValid ? w_head.first : 1'b0;
  assign out_local.last  = w_localValid ? w_head.last  : 1'b0;

  assign out_ring.valid  = w_ringValid;
  assign out_ring.data   = w_ringValid ? w_head.data  : '0;
  assign out_ring.first  = w_ringValid ? w_head.first : 1'b0;
  assign out_ring.last   = w_ringValid ? w_head.last  : 1'b0;

`ifdef RING_ROUTER_DEMUX_STATS_EN
  logic [15:0] r_statLocal;
  logic [15:0] r_statRing;
  logic [15:0] r_statDrop;

  // A packet is counted when its last flit leaves the buffer, under the
  // route that flit took.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_statLocal <= 16'd0;
      r_statRing  <= 16'd0;
      r_statDrop  <= 16'd0;
    end else if (w_pop && w_head.last) begin
      case (w_route)
        ROUTE_LOCAL: r_statLocal <= satInc(r_statLocal);
        ROUTE_RING:  r_statRing  <= satInc(r_statRing);
        default:     r_statDrop  <= satInc(r_statDrop);
      endcase
    end
  end

  assign stat_local = r_statLocal;
  assign stat_ring  = r_statRing;
  assign stat_drop  = r_statDrop;
`endif

endmodule
